// File: rtl/batch_former_pkg.sv
// Shared definitions for the batch former: default sizes, FSM state encoding
// and a small width helper used by the top and the ID allocator.
package batch_former_pkg;

    localparam int DEF_MAX_DEPENDENCIES = 1024;
    localparam int DEF_MAX_BATCHES      = 16;
    localparam int DEF_MAX_BATCH_SIZE   = 8;
    localparam int DEF_TIMEOUT_CYCLES   = 64;
    localparam int OWNER_W              = 64;
    localparam int COUNTER_W            = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CLOSE   = 2'd2,
        ST_WAIT_ID = 2'd3
    } bf_state_e;

    // Index width for a pool of n entries; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/batch_former_if.sv
// Transaction offer channel into the batch former: valid/ready handshake plus
// the read/write dependency sets and owner of the offered transaction.
interface batch_former_if #(
    parameter int DEP_W = 1024
);
    import batch_former_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [DEP_W-1:0]   in_read_deps;
    logic [DEP_W-1:0]   in_write_deps;
    logic [OWNER_W-1:0] in_owner_id;

    modport master (
        output in_valid,
        output in_read_deps,
        output in_write_deps,
        output in_owner_id,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_read_deps,
        input  in_write_deps,
        input  in_owner_id,
        output in_ready
    );

endinterface

// File: rtl/batch_former_id_allocator.sv
// Batch ID pool: free bitmap with lowest-index allocation, frees on batch
// completion and flags completions that name an ID which is already free.
module batch_id_allocator
    import batch_former_pkg::*;
#(
    parameter int NUM_IDS = DEF_MAX_BATCHES,
    parameter int ID_W    = id_width(NUM_IDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_req,
    output logic               any_free,
    output logic [ID_W-1:0]    alloc_id,
    input  logic               free_req,
    input  logic [ID_W-1:0]    free_id,
    output logic [NUM_IDS-1:0] free_ids,
    output logic               free_error
);

    logic [NUM_IDS-1:0] free_ids_q, free_ids_d;
    logic               free_error_q, free_error_d;

    // Lowest-index free ID; scanning downward lets the smallest index win.
    always_comb begin
        alloc_id = '0;
        any_free = |free_ids_q;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (free_ids_q[i]) begin
                alloc_id = ID_W'(i);
            end
        end
    end

    // Bitmap update: allocation and freeing both act on the pre-edge bitmap.
    always_comb begin
        free_ids_d   = free_ids_q;
        free_error_d = 1'b0;
        if (alloc_req && any_free) begin
            free_ids_d[alloc_id] = 1'b0;
        end
        if (free_req && (int'(free_id) < NUM_IDS)) begin
            if (free_ids_q[free_id]) begin
                free_error_d = 1'b1;
            end else begin
                free_ids_d[free_id] = 1'b1;
            end
        end
    end

    // Bitmap and error pulse registers; reset returns every ID to the pool.
    always_ff @(posedge clk) begin
        if (rst) begin
            free_ids_q   <= '1;
            free_error_q <= 1'b0;
        end else begin
            free_ids_q   <= free_ids_d;
            free_error_q <= free_error_d;
        end
    end

    assign free_ids   = free_ids_q;
    assign free_error = free_error_q;

endmodule

// File: rtl/batch_former.sv
// Batch former: gathers mutually non-conflicting transactions into an open
// batch, closes it on size/timeout/conflict/flush, then registers it with the
// conflict manager under a freshly allocated batch ID.
module batch_former
    import batch_former_pkg::*;
#(
    parameter int MAX_DEPENDENCIES = DEF_MAX_DEPENDENCIES,
    parameter int MAX_BATCHES      = DEF_MAX_BATCHES,
    parameter int MAX_BATCH_SIZE   = DEF_MAX_BATCH_SIZE,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
    parameter int BID_W            = id_width(MAX_BATCHES),
    parameter int SIZE_W           = $clog2(MAX_BATCH_SIZE + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    batch_former_if.slave               in_bus,
    input  logic                        flush,
    output logic                        cm_txn_valid,
    input  logic                        cm_has_conflict,
    output logic                        new_batch_valid,
    output logic [BID_W-1:0]            new_batch_id,
    output logic [MAX_DEPENDENCIES-1:0] new_batch_read_deps,
    output logic [MAX_DEPENDENCIES-1:0] new_batch_write_deps,
    output logic [OWNER_W-1:0]          new_batch_owner_id,
    output logic [SIZE_W-1:0]           new_batch_size,
    input  logic                        batch_completed,
    input  logic [BID_W-1:0]            batch_id,
    output logic [MAX_BATCHES-1:0]      free_ids,
    output logic [COUNTER_W-1:0]        batches_formed,
    output logic [COUNTER_W-1:0]        stall_cycles,
    output logic                        free_error
);

    localparam int TIMER_W = id_width(TIMEOUT_CYCLES);

    bf_state_e                   state_q, state_d;
    logic [MAX_DEPENDENCIES-1:0] open_read_q, open_read_d;
    logic [MAX_DEPENDENCIES-1:0] open_write_q, open_write_d;
    logic [OWNER_W-1:0]          open_owner_q, open_owner_d;
    logic [SIZE_W-1:0]           count_q, count_d;
    logic [TIMER_W-1:0]          timer_q, timer_d;

    logic                        nb_valid_q, nb_valid_d;
    logic [BID_W-1:0]            nb_id_q, nb_id_d;
    logic [MAX_DEPENDENCIES-1:0] nb_read_q, nb_read_d;
    logic [MAX_DEPENDENCIES-1:0] nb_write_q, nb_write_d;
    logic [OWNER_W-1:0]          nb_owner_q, nb_owner_d;
    logic [SIZE_W-1:0]           nb_size_q, nb_size_d;
    logic [COUNTER_W-1:0]        formed_q, formed_d;
    logic [COUNTER_W-1:0]        stall_q, stall_d;

    logic             ready_int;
    logic             accept;
    logic             local_conflict;
    logic             alloc_req;
    logic             any_free;
    logic [BID_W-1:0] alloc_id;

    batch_id_allocator #(
        .NUM_IDS (MAX_BATCHES),
        .ID_W    (BID_W)
    ) u_alloc (
        .clk        (clk),
        .rst        (rst),
        .alloc_req  (alloc_req),
        .any_free   (any_free),
        .alloc_id   (alloc_id),
        .free_req   (batch_completed),
        .free_id    (batch_id),
        .free_ids   (free_ids),
        .free_error (free_error)
    );

    // Offered transaction against the open batch: RAW, WAW and WAR hazards.
    always_comb begin
        local_conflict = (|(in_bus.in_read_deps  & open_write_q))
                       | (|(in_bus.in_write_deps & open_write_q))
                       | (|(in_bus.in_write_deps & open_read_q));
    end

    // FSM next state, open-batch accumulation, registration and counters.
    always_comb begin
        state_d      = state_q;
        open_read_d  = open_read_q;
        open_write_d = open_write_q;
        open_owner_d = open_owner_q;
        count_d      = count_q;
        timer_d      = timer_q;
        nb_valid_d   = 1'b0;
        nb_id_d      = nb_id_q;
        nb_read_d    = nb_read_q;
        nb_write_d   = nb_write_q;
        nb_owner_d   = nb_owner_q;
        nb_size_d    = nb_size_q;
        formed_d     = formed_q;
        alloc_req    = 1'b0;
        ready_int    = 1'b0;
        accept       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_int = !cm_has_conflict;
                accept    = in_bus.in_valid && ready_int;
                if (accept) begin
                    open_read_d  = in_bus.in_read_deps;
                    open_write_d = in_bus.in_write_deps;
                    open_owner_d = in_bus.in_owner_id;
                    count_d      = SIZE_W'(1);
                    timer_d      = '0;
                    state_d      = (MAX_BATCH_SIZE == 1) ? ST_CLOSE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                ready_int = !cm_has_conflict && !local_conflict;
                accept    = in_bus.in_valid && ready_int;
                if (accept) begin
                    open_read_d  = open_read_q | in_bus.in_read_deps;
                    open_write_d = open_write_q | in_bus.in_write_deps;
                    count_d      = count_q + SIZE_W'(1);
                    timer_d      = '0;
                    if ((count_q == SIZE_W'(MAX_BATCH_SIZE - 1)) || flush) begin
                        state_d = ST_CLOSE;
                    end
                end else if (flush
                             || (in_bus.in_valid && local_conflict && !cm_has_conflict)
                             || (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1))) begin
                    state_d = ST_CLOSE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_CLOSE, ST_WAIT_ID: begin
                if (any_free) begin
                    alloc_req  = 1'b1;
                    nb_valid_d = 1'b1;
                    nb_id_d    = alloc_id;
                    nb_read_d  = open_read_q;
                    nb_write_d = open_write_q;
                    nb_owner_d = open_owner_q;
                    nb_size_d  = count_q;
                    formed_d   = formed_q + COUNTER_W'(1);
                    count_d    = '0;
                    timer_d    = '0;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_ID;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        stall_d = stall_q + COUNTER_W'(in_bus.in_valid && !ready_int);
    end

    // State, open batch, registration outputs and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            open_read_q  <= '0;
            open_write_q <= '0;
            open_owner_q <= '0;
            count_q      <= '0;
            timer_q      <= '0;
            nb_valid_q   <= 1'b0;
            nb_id_q      <= '0;
            nb_read_q    <= '0;
            nb_write_q   <= '0;
            nb_owner_q   <= '0;
            nb_size_q    <= '0;
            formed_q     <= '0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            open_read_q  <= open_read_d;
            open_write_q <= open_write_d;
            open_owner_q <= open_owner_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            nb_valid_q   <= nb_valid_d;
            nb_id_q      <= nb_id_d;
            nb_read_q    <= nb_read_d;
            nb_write_q   <= nb_write_d;
            nb_owner_q   <= nb_owner_d;
            nb_size_q    <= nb_size_d;
            formed_q     <= formed_d;
            stall_q      <= stall_d;
        end
    end

    assign in_bus.in_ready      = ready_int && !rst;
    assign cm_txn_valid         = in_bus.in_valid && !rst
                                  && ((state_q == ST_IDLE) || (state_q == ST_COLLECT));
    assign new_batch_valid      = nb_valid_q;
    assign new_batch_id         = nb_id_q;
    assign new_batch_read_deps  = nb_read_q;
    assign new_batch_write_deps = nb_write_q;
    assign new_batch_owner_id   = nb_owner_q;
    assign new_batch_size       = nb_size_q;
    assign batches_formed       = formed_q;
    assign stall_cycles         = stall_q;

endmodule

// File: tb/tb_batch_former.sv
// Self-checking bench for batch_former: a table of single-cycle admission
// vectors plus directed multi-cycle sequences for close, ID and reset cases.
module tb_batch_former;
    import batch_former_pkg::*;

    localparam int DEP   = 1024;
    localparam int NB    = 16;
    localparam int BID_W = 4;
    localparam int SZ_W  = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             cm_txn_valid;
    logic             cm_has_conflict;
    logic             new_batch_valid;
    logic [BID_W-1:0] new_batch_id;
    logic [DEP-1:0]   new_batch_read_deps;
    logic [DEP-1:0]   new_batch_write_deps;
    logic [63:0]      new_batch_owner_id;
    logic [SZ_W-1:0]  new_batch_size;
    logic             batch_completed;
    logic [BID_W-1:0] batch_id;
    logic [NB-1:0]    free_ids;
    logic [31:0]      batches_formed;
    logic [31:0]      stall_cycles;
    logic             free_error;

    int checks = 0;
    int errors = 0;

    batch_former_if #(.DEP_W(DEP)) bus ();

    batch_former dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_bus               (bus.slave),
        .flush                (flush),
        .cm_txn_valid         (cm_txn_valid),
        .cm_has_conflict      (cm_has_conflict),
        .new_batch_valid      (new_batch_valid),
        .new_batch_id         (new_batch_id),
        .new_batch_read_deps  (new_batch_read_deps),
        .new_batch_write_deps (new_batch_write_deps),
        .new_batch_owner_id   (new_batch_owner_id),
        .new_batch_size       (new_batch_size),
        .batch_completed      (batch_completed),
        .batch_id             (batch_id),
        .free_ids             (free_ids),
        .batches_formed       (batches_formed),
        .stall_cycles         (stall_cycles),
        .free_error           (free_error)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] wr;
        logic        cm;
        logic        exp_ready;
        logic        exp_cm_valid;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic checkWide(input string name, input logic [DEP-1:0] actual, input logic [DEP-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual(low64)=%0h expected(low64)=%0h", name, actual[63:0], expected[63:0]);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.in_read_deps        = '0;
        bus.in_write_deps       = '0;
        bus.in_read_deps[31:0]  = v.rd;
        bus.in_write_deps[31:0] = v.wr;
        bus.in_owner_id         = 64'h77;
        cm_has_conflict         = v.cm;
        bus.in_valid            = 1'b1;
        #1;
    endtask

    task automatic doReset();
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        flush           = 1'b0;
        cm_has_conflict = 1'b0;
        batch_completed = 1'b0;
        batch_id        = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Offer a transaction and wait (bounded) until the DUT takes it.
    task automatic sendTxn(input logic [31:0] rd, input logic [31:0] wr, input logic [63:0] owner);
        logic got;
        logic accepted;
        accepted                = 1'b0;
        bus.in_read_deps        = '0;
        bus.in_write_deps       = '0;
        bus.in_read_deps[31:0]  = rd;
        bus.in_write_deps[31:0] = wr;
        bus.in_owner_id         = owner;
        bus.in_valid            = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            #1;
            got = bus.in_ready;
            tick();
            if (got) accepted = 1'b1;
        end
        bus.in_valid = 1'b0;
        if (!accepted) begin
            errors++;
            $display("[TB] FAIL accept_timeout actual=0 expected=1");
        end
        checks++;
    endtask

    task automatic flushClose();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DEP-1:0] exp_w;
        logic [DEP-1:0] exp_r;
        int n;

        vecs[0] = '{rd: 32'h2,        wr: 32'h4,        cm: 1'b0, exp_ready: 1'b1, exp_cm_valid: 1'b1};
        vecs[1] = '{rd: 32'h0010_0000, wr: 32'h0,        cm: 1'b0, exp_ready: 1'b0, exp_cm_valid: 1'b1};
        vecs[2] = '{rd: 32'h0,        wr: 32'h0010_0000, cm: 1'b0, exp_ready: 1'b0, exp_cm_valid: 1'b1};
        vecs[3] = '{rd: 32'h0,        wr: 32'h400,      cm: 1'b0, exp_ready: 1'b0, exp_cm_valid: 1'b1};
        vecs[4] = '{rd: 32'h400,      wr: 32'h0,        cm: 1'b0, exp_ready: 1'b1, exp_cm_valid: 1'b1};
        vecs[5] = '{rd: 32'h2,        wr: 32'h0,        cm: 1'b1, exp_ready: 1'b0, exp_cm_valid: 1'b1};
        vecs[6] = '{rd: 32'h0010_0000, wr: 32'h0,        cm: 1'b1, exp_ready: 1'b0, exp_cm_valid: 1'b1};

        bus.in_read_deps  = '0;
        bus.in_write_deps = '0;
        bus.in_owner_id   = '0;
        doReset();

        // Reset state, including in_ready held low while reset is asserted.
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'h0);
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        checkOutput("rst_free_ids", 64'(free_ids), 64'hFFFF);
        checkOutput("rst_nb_valid", 64'(new_batch_valid), 64'h0);
        checkOutput("rst_formed", 64'(batches_formed), 64'h0);
        checkOutput("rst_stall", 64'(stall_cycles), 64'h0);

        // Admission table against an open batch reading bit 10, writing bit 20.
        sendTxn(32'h400, 32'h0010_0000, 64'h1);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_ready", i), 64'(bus.in_ready), 64'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d_cm_valid", i), 64'(cm_txn_valid), 64'(vecs[i].exp_cm_valid));
        end
        bus.in_valid    = 1'b0;
        cm_has_conflict = 1'b0;
        doReset();

        // Three disjoint writers, then the idle timeout closes the batch.
        sendTxn(32'h0, 32'h1, 64'd100);
        sendTxn(32'h0, 32'h2, 64'd101);
        sendTxn(32'h0, 32'h4, 64'd102);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (new_batch_valid) begin
                n = i;
                break;
            end
        end
        checkOutput("to_latency", 64'(n), 64'd65);
        exp_w = '0;
        exp_w[2:0] = 3'b111;
        checkWide("to_write_deps", new_batch_write_deps, exp_w);
        checkWide("to_read_deps", new_batch_read_deps, '0);
        checkOutput("to_size", 64'(new_batch_size), 64'd3);
        checkOutput("to_id", 64'(new_batch_id), 64'd0);
        checkOutput("to_owner", 64'(new_batch_owner_id), 64'd100);
        tick();
        checkOutput("to_pulse_width", 64'(new_batch_valid), 64'h0);
        checkWide("to_write_held", new_batch_write_deps, exp_w);
        checkOutput("to_formed", 64'(batches_formed), 64'd1);
        checkOutput("to_free_ids", 64'(free_ids), 64'hFFFE);
        doReset();

        // Eight back-to-back disjoint writers fill a batch; ninth opens ID 1.
        for (int i = 0; i < 8; i++) begin
            sendTxn(32'h0, 32'(1) << i, 64'(200 + i));
        end
        checkOutput("full_no_early", 64'(new_batch_valid), 64'h0);
        tick();
        checkOutput("full_valid", 64'(new_batch_valid), 64'h1);
        checkOutput("full_size", 64'(new_batch_size), 64'd8);
        checkOutput("full_id", 64'(new_batch_id), 64'd0);
        checkOutput("full_write", new_batch_write_deps[63:0], 64'hFF);
        checkOutput("full_owner", 64'(new_batch_owner_id), 64'd200);
        sendTxn(32'h0, 32'h100, 64'd300);
        flushClose();
        checkOutput("ninth_valid", 64'(new_batch_valid), 64'h1);
        checkOutput("ninth_id", 64'(new_batch_id), 64'd1);
        checkOutput("ninth_size", 64'(new_batch_size), 64'd1);
        checkOutput("ninth_owner", 64'(new_batch_owner_id), 64'd300);
        doReset();

        // A writes bit 5, B reads bit 5: A closes alone, B waits for A to retire.
        sendTxn(32'h0, 32'h20, 64'hA);
        bus.in_read_deps        = '0;
        bus.in_write_deps       = '0;
        bus.in_read_deps[31:0]  = 32'h20;
        bus.in_owner_id         = 64'hB;
        bus.in_valid            = 1'b1;
        #1;
        checkOutput("raw_b_held", 64'(bus.in_ready), 64'h0);
        tick();
        tick();
        checkOutput("raw_a_valid", 64'(new_batch_valid), 64'h1);
        checkOutput("raw_a_size", 64'(new_batch_size), 64'd1);
        checkOutput("raw_a_write", new_batch_write_deps[63:0], 64'h20);
        checkOutput("raw_a_owner", 64'(new_batch_owner_id), 64'hA);
        cm_has_conflict = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("raw_b_stalled", 64'(bus.in_ready), 64'h0);
            tick();
        end
        checkOutput("raw_free_before", 64'(free_ids), 64'hFFFE);
        batch_completed = 1'b1;
        batch_id        = 4'd0;
        tick();
        batch_completed = 1'b0;
        cm_has_conflict = 1'b0;
        checkOutput("raw_free_after", 64'(free_ids), 64'hFFFF);
        #1;
        checkOutput("raw_b_ready", 64'(bus.in_ready), 64'h1);
        tick();
        bus.in_valid = 1'b0;
        flushClose();
        checkOutput("raw_b_valid", 64'(new_batch_valid), 64'h1);
        checkOutput("raw_b_id", 64'(new_batch_id), 64'd0);
        checkOutput("raw_b_read", new_batch_read_deps[63:0], 64'h20);
        checkOutput("raw_b_write", new_batch_write_deps[63:0], 64'h0);
        checkOutput("raw_b_owner", 64'(new_batch_owner_id), 64'hB);
        doReset();

        // External conflict for ten cycles: stalls counted, nothing else moves.
        cm_has_conflict         = 1'b1;
        bus.in_read_deps        = '0;
        bus.in_write_deps       = '0;
        bus.in_write_deps[31:0] = 32'h1;
        bus.in_valid            = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput("cm_stall_ready", 64'(bus.in_ready), 64'h0);
            tick();
        end
        bus.in_valid = 1'b0;
        checkOutput("cm_stall_count", 64'(stall_cycles), 64'd10);
        checkOutput("cm_stall_formed", 64'(batches_formed), 64'd0);
        checkOutput("cm_stall_free", 64'(free_ids), 64'hFFFF);
        cm_has_conflict = 1'b0;
        bus.in_valid    = 1'b1;
        #1;
        checkOutput("cm_stall_idle_ready", 64'(bus.in_ready), 64'h1);
        checkOutput("cm_stall_idle_cmv", 64'(cm_txn_valid), 64'h1);
        bus.in_valid = 1'b0;
        doReset();

        // Exhaust all sixteen IDs, then the seventeenth batch waits for ID 3.
        for (int i = 0; i < 16; i++) begin
            sendTxn(32'h0, 32'(1) << i, 64'(i));
            flushClose();
            checkOutput($sformatf("fill_id%0d", i), 64'(new_batch_id), 64'(i));
        end
        checkOutput("fill_free_empty", 64'(free_ids), 64'h0);
        sendTxn(32'h0, 32'h1_0000, 64'd16);
        flushClose();
        checkOutput("wait_no_pulse", 64'(new_batch_valid), 64'h0);
        bus.in_valid = 1'b1;
        #1;
        checkOutput("wait_in_ready", 64'(bus.in_ready), 64'h0);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("wait_still_none", 64'(new_batch_valid), 64'h0);
        batch_completed = 1'b1;
        batch_id        = 4'd3;
        tick();
        batch_completed = 1'b0;
        checkOutput("wait_same_cycle", 64'(new_batch_valid), 64'h0);
        tick();
        checkOutput("wait_valid", 64'(new_batch_valid), 64'h1);
        checkOutput("wait_id", 64'(new_batch_id), 64'd3);
        checkOutput("wait_write", new_batch_write_deps[63:0], 64'h1_0000);
        checkOutput("wait_formed", 64'(batches_formed), 64'd17);
        checkOutput("wait_free", 64'(free_ids), 64'h0);
        doReset();

        // Completing an ID that is already free raises a one-cycle error.
        batch_completed = 1'b1;
        batch_id        = 4'd7;
        tick();
        batch_completed = 1'b0;
        checkOutput("ferr_pulse", 64'(free_error), 64'h1);
        checkOutput("ferr_free", 64'(free_ids), 64'hFFFF);
        tick();
        checkOutput("ferr_clear", 64'(free_error), 64'h0);

        // Reset in the middle of collecting discards the batch and frees IDs.
        sendTxn(32'h0, 32'h1, 64'd1);
        flushClose();
        checkOutput("mid_pre_free", 64'(free_ids), 64'hFFFE);
        sendTxn(32'h0, 32'h2, 64'd2);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("mid_free", 64'(free_ids), 64'hFFFF);
        checkOutput("mid_formed", 64'(batches_formed), 64'd0);
        n = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (new_batch_valid) n++;
        end
        checkOutput("mid_no_pulse", 64'(n), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
